// File: rtl/addsub_ctrl_if.sv
// Command, response and datapath-drive signals of the addsub_ctrl sequencer.
// slave = the controller itself; master = command source, consumer and AddSub datapath.
interface addsub_ctrl_if #(
    parameter int unsigned size = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [size-1:0] cmd_data;
    logic [size-1:0] left_o;
    logic [size-1:0] right_o;
    logic [1:0]      addsub_o;
    logic [size-1:0] res_i;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [size-1:0] rsp_data;
    logic            ovf_o;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, res_i, rsp_ready,
        output cmd_ready, left_o, right_o, addsub_o, rsp_valid, rsp_data, ovf_o
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, res_i, rsp_ready,
        input  cmd_ready, left_o, right_o, addsub_o, rsp_valid, rsp_data, ovf_o
    );
endinterface

// File: rtl/addsub_ctrl.sv
// Accumulator sequencer driving an external AddSub datapath (1 add, 0 sub, 2 hold).
// Define ADDSUB_CTRL_SAT_EN to make ADD/SUB saturate and report ovf_o.
module addsub_ctrl #(
    parameter int unsigned size = 4
) (
    input logic          clk,
    input logic          rst_n,
    addsub_ctrl_if.slave bus
);
    localparam int unsigned IW = (size > 1) ? $clog2(size) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(size - 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_CLR} op_t;

    state_t          state, state_d;
    op_t             op, op_d;
    logic [size-1:0] operand, operand_d;
    logic [size-1:0] acc, acc_d;
    logic [size-1:0] product, product_d;
    logic [IW-1:0]   idx, idx_d;
`ifdef ADDSUB_CTRL_SAT_EN
    logic            ovf, ovf_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op      <= OP_ADD;
            operand <= '0;
            acc     <= '0;
            product <= '0;
            idx     <= '0;
`ifdef ADDSUB_CTRL_SAT_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            op      <= op_d;
            operand <= operand_d;
            acc     <= acc_d;
            product <= product_d;
            idx     <= idx_d;
`ifdef ADDSUB_CTRL_SAT_EN
            ovf     <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d      = state;
        op_d         = op;
        operand_d    = operand;
        acc_d        = acc;
        product_d    = product;
        idx_d        = idx;
`ifdef ADDSUB_CTRL_SAT_EN
        ovf_d        = ovf;
`endif
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.ovf_o     = 1'b0;
        bus.left_o    = '0;
        bus.right_o   = '0;
        bus.addsub_o  = 2'd2;

        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    op_d      = op_t'(bus.cmd_op);
                    operand_d = bus.cmd_data;
`ifdef ADDSUB_CTRL_SAT_EN
                    ovf_d     = 1'b0;
`endif
                    case (op_t'(bus.cmd_op))
                        OP_ADD, OP_SUB: state_d = EXEC;
                        OP_MUL: begin
                            product_d = '0;
                            idx_d     = '0;
                            state_d   = MUL;
                        end
                        default: begin
                            acc_d   = '0;
                            state_d = DONE;
                        end
                    endcase
                end
            end

            EXEC: begin
                bus.left_o   = acc;
                bus.right_o  = operand;
                bus.addsub_o = (op == OP_ADD) ? 2'd1 : 2'd0;
                acc_d        = bus.res_i;
`ifdef ADDSUB_CTRL_SAT_EN
                if (op == OP_ADD && bus.res_i < acc) begin
                    acc_d = '1;
                    ovf_d = 1'b1;
                end else if (op != OP_ADD && acc < operand) begin
                    acc_d = '0;
                    ovf_d = 1'b1;
                end
`endif
                state_d = DONE;
            end

            MUL: begin
                bus.left_o  = product;
                bus.right_o = acc << idx;
                if (operand[idx]) begin
                    bus.addsub_o = 2'd1;
                    product_d    = bus.res_i;
                end
                // The last partial sum is taken straight from product_d so it is not lost.
                if (idx == LAST_IDX) begin
                    acc_d   = product_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx + IW'(1);
                end
            end

            DONE: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = acc;
`ifdef ADDSUB_CTRL_SAT_EN
                bus.ovf_o     = ovf;
`endif
                if (bus.rsp_ready) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_addsub_ctrl.sv
// Directed bench for addsub_ctrl with a behavioural AddSub datapath on res_i.
// Expected values follow ADDSUB_CTRL_SAT_EN when it is defined.
module tb_addsub_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int unsigned checks = 0;
    int unsigned errors = 0;

    addsub_ctrl_if #(.size(4)) bus ();

    addsub_ctrl #(.size(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.res_i = (bus.addsub_o == 2'd1) ? bus.left_o + bus.right_o :
                       (bus.addsub_o == 2'd0) ? bus.left_o - bus.right_o : bus.left_o;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("back_to_idle", bus.cmd_ready, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_data"},  bus.rsp_data, 0);
        chk({tag, "_ovf"},       bus.ovf_o, 0);
        chk({tag, "_addsub"},    bus.addsub_o, 2);
        chk({tag, "_left"},      bus.left_o, 0);
        chk({tag, "_right"},     bus.right_o, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 4'd0;
        bus.rsp_ready = 1'b0;
        #12;
        chk_reset("reset");
        rst_n = 1'b1;
        step();

        // ADD 5: EXEC in cycle 1, DONE in cycle 2
        cmd(2'd0, 4'd5);
        chk("add_exec_addsub", bus.addsub_o, 1);
        chk("add_exec_right", bus.right_o, 5);
        chk("add_exec_left", bus.left_o, 0);
        chk("add_exec_cmd_ready", bus.cmd_ready, 0);
        chk("add_exec_rsp_valid", bus.rsp_valid, 0);
        step();
        chk("add_done_valid", bus.rsp_valid, 1);
        chk("add_done_data", bus.rsp_data, 5);
        chk("add_done_addsub", bus.addsub_o, 2);
        finish_rsp();

        // SUB 7 from 5
        cmd(2'd1, 4'd7);
        chk("sub_exec_addsub", bus.addsub_o, 0);
        step();
        chk("sub_valid", bus.rsp_valid, 1);
`ifdef ADDSUB_CTRL_SAT_EN
        chk("sub_data", bus.rsp_data, 0);
        chk("sub_ovf", bus.ovf_o, 1);
`else
        chk("sub_data", bus.rsp_data, 14);
        chk("sub_ovf", bus.ovf_o, 0);
`endif
        finish_rsp();

        // CLR then ADD 3, then MUL 5 -> 15
        cmd(2'd3, 4'd0);
        chk("clr1_valid", bus.rsp_valid, 1);
        chk("clr1_data", bus.rsp_data, 0);
        finish_rsp();
        cmd(2'd0, 4'd3);
        step();
        chk("acc3", bus.rsp_data, 3);
        finish_rsp();
        cmd(2'd2, 4'd5);
        chk("mul5_c1_addsub", bus.addsub_o, 1);
        chk("mul5_c1_right", bus.right_o, 3);
        chk("mul5_c1_left", bus.left_o, 0);
        step();
        chk("mul5_c2_addsub", bus.addsub_o, 2);
        chk("mul5_c2_valid", bus.rsp_valid, 0);
        step();
        chk("mul5_c3_addsub", bus.addsub_o, 1);
        chk("mul5_c3_right", bus.right_o, 12);
        chk("mul5_c3_left", bus.left_o, 3);
        step();
        chk("mul5_c4_addsub", bus.addsub_o, 2);
        chk("mul5_c4_valid", bus.rsp_valid, 0);
        step();
        chk("mul5_c5_valid", bus.rsp_valid, 1);
        chk("mul5_c5_data", bus.rsp_data, 15);
        finish_rsp();

        // acc 6, MUL 3 wraps to 2; stall response with a pending command
        cmd(2'd3, 4'd0);
        finish_rsp();
        cmd(2'd0, 4'd6);
        step();
        finish_rsp();
        cmd(2'd2, 4'd3);
        repeat (3) step();
        chk("mul3_c4_valid", bus.rsp_valid, 0);
        step();
        chk("mul3_valid", bus.rsp_valid, 1);
        chk("mul3_data", bus.rsp_data, 2);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 4'd1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", bus.rsp_valid, 1);
            chk("stall_data", bus.rsp_data, 2);
            chk("stall_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        step();
        bus.rsp_ready = 1'b0;
        chk("stall_release_ready", bus.cmd_ready, 1);
        chk("stall_release_valid", bus.rsp_valid, 0);

        // acc 2, MUL 3, reset during the second MUL cycle
        cmd(2'd2, 4'd3);
        chk("rmul_c1_addsub", bus.addsub_o, 1);
        chk("rmul_c1_right", bus.right_o, 2);
        step();
        chk("rmul_c2_addsub", bus.addsub_o, 1);
        chk("rmul_c2_right", bus.right_o, 4);
        chk("rmul_c2_left", bus.left_o, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("midmul");
        #2 rst_n = 1'b1;
        step();
        step();
        chk("post_rst_valid", bus.rsp_valid, 0);
        chk("post_rst_addsub", bus.addsub_o, 2);
        cmd(2'd0, 4'd1);
        step();
        chk("post_rst_add1", bus.rsp_data, 1);
        finish_rsp();

        // acc 9, CLR
        cmd(2'd0, 4'd8);
        step();
        chk("acc9", bus.rsp_data, 9);
        finish_rsp();
        cmd(2'd3, 4'd0);
        chk("clr9_valid", bus.rsp_valid, 1);
        chk("clr9_data", bus.rsp_data, 0);
        chk("clr9_ovf", bus.ovf_o, 0);
        finish_rsp();

        // ADD overflow: 15 + 3
        cmd(2'd0, 4'd15);
        step();
        chk("acc15", bus.rsp_data, 15);
        chk("acc15_ovf", bus.ovf_o, 0);
        finish_rsp();
        cmd(2'd0, 4'd3);
        step();
`ifdef ADDSUB_CTRL_SAT_EN
        chk("add_ovf_data", bus.rsp_data, 15);
        chk("add_ovf_flag", bus.ovf_o, 1);
`else
        chk("add_ovf_data", bus.rsp_data, 2);
        chk("add_ovf_flag", bus.ovf_o, 0);
`endif
        finish_rsp();

        // MUL by 0: every cycle holds, result 0
        cmd(2'd2, 4'd0);
        for (int k = 0; k < 4; k++) begin
            chk("mul0_addsub", bus.addsub_o, 2);
            step();
        end
        chk("mul0_valid", bus.rsp_valid, 1);
        chk("mul0_data", bus.rsp_data, 0);
        chk("mul0_ovf", bus.ovf_o, 0);
        finish_rsp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
